// File: rtl/ddr3_test_ctrl.sv
// Write/read-back pattern tester for a MIG DDR3 user interface (256-bit app port).
// Optional first-mismatch capture ports (err_addr, err_data) enabled by DDR3_ERR_CAPTURE_EN.
module ddr3_test_ctrl #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned ADDR_STEP = 8,
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic         ui_clk,
  input  logic         ui_clk_sync_rst,
  input  logic         init_calib_complete,
  input  logic         start,
  output logic [29:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [255:0] app_wdf_data,
  output logic [31:0]  app_wdf_mask,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  input  logic         app_wdf_rdy,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count
`ifdef DDR3_ERR_CAPTURE_EN
  ,
  output logic [29:0]  err_addr,
  output logic [255:0] err_data
`endif
);

  localparam logic [16:0] NW     = 17'(NUM_WORDS);
  localparam logic [29:0] STEP   = 30'(ADDR_STEP);
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic [2:0] {IDLE, WAIT_CAL, WRITE, READ, DRAIN, DONE} state_t;

  state_t        state, state_n;
  logic [16:0]   cmd_cnt, cmd_cnt_n;
  logic [16:0]   dat_cnt, dat_cnt_n;
  logic [16:0]   rd_cnt, rd_cnt_n;
  logic [15:0]   err_n;
  logic          en_n, wren_n, done_n, pass_n;
  logic [2:0]    cmd_n;
  logic [29:0]   addr_n;
  logic [255:0]  data_n;
  logic          cmd_acc, dat_acc, rd_take, rd_bad;
`ifdef DDR3_ERR_CAPTURE_EN
  logic [29:0]   rd_addr, rd_addr_n, err_addr_n;
  logic [255:0]  err_data_n;
`endif

  function automatic logic [255:0] pattern(input logic [16:0] idx);
    return {8{SEED ^ {15'd0, idx}}};
  endfunction

  assign cmd_acc      = app_en && app_rdy;
  assign dat_acc      = app_wdf_wren && app_wdf_rdy;
  assign rd_take      = app_rd_data_valid && (state == READ || state == DRAIN) && (rd_cnt < NW);
  assign rd_bad       = rd_take && (app_rd_data != pattern(rd_cnt));
  assign busy         = (state != IDLE) && (state != DONE);
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_mask = '0;

  always_comb begin
    state_n   = state;
    cmd_cnt_n = cmd_cnt;
    dat_cnt_n = dat_cnt;
    rd_cnt_n  = rd_cnt;
    err_n     = err_count;
    en_n      = 1'b0;
    wren_n    = 1'b0;
    cmd_n     = app_cmd;
    addr_n    = app_addr;
    data_n    = app_wdf_data;
    done_n    = done;
    pass_n    = pass;
`ifdef DDR3_ERR_CAPTURE_EN
    rd_addr_n  = rd_addr;
    err_addr_n = err_addr;
    err_data_n = err_data;
`endif

    if (rd_take) begin
      rd_cnt_n = rd_cnt + 17'd1;
      if (rd_bad && err_count != '1) err_n = err_count + 16'd1;
`ifdef DDR3_ERR_CAPTURE_EN
      rd_addr_n = rd_addr + STEP;
      if (rd_bad && err_count == '0) begin
        err_addr_n = rd_addr;
        err_data_n = app_rd_data;
      end
`endif
    end

    case (state)
      IDLE: if (start) state_n = WAIT_CAL;

      WAIT_CAL: if (init_calib_complete) begin
        state_n   = WRITE;
        cmd_cnt_n = '0;
        dat_cnt_n = '0;
        rd_cnt_n  = '0;
        err_n     = '0;
        cmd_n     = CMD_WR;
        addr_n    = BASE_ADDR;
        wren_n    = 1'b1;
        data_n    = pattern('0);
`ifdef DDR3_ERR_CAPTURE_EN
        rd_addr_n  = BASE_ADDR;
        err_addr_n = '0;
        err_data_n = '0;
`endif
      end

      WRITE: begin
        if (!init_calib_complete) begin
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = 1'b0;
        end else if (cmd_cnt == NW && dat_cnt == NW) begin
          state_n   = READ;
          cmd_cnt_n = '0;
          cmd_n     = CMD_RD;
          addr_n    = BASE_ADDR;
          en_n      = 1'b1;
        end else begin
          cmd_cnt_n = cmd_cnt + {16'd0, cmd_acc};
          dat_cnt_n = dat_cnt + {16'd0, dat_acc};
          if (cmd_acc) addr_n = app_addr + STEP;
          // A command is only offered for a word whose data has already transferred,
          // so data leads by 1..2 words and can never fall behind.
          en_n = (app_en && !app_rdy) || (cmd_cnt_n < NW && cmd_cnt_n < dat_cnt_n);
          if (app_wdf_wren && !app_wdf_rdy) begin
            wren_n = 1'b1;
          end else if (dat_cnt_n < NW && (dat_cnt_n - cmd_cnt_n) < 17'd2) begin
            wren_n = 1'b1;
            data_n = pattern(dat_cnt_n);
          end
        end
      end

      READ: begin
        if (!init_calib_complete) begin
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = 1'b0;
        end else begin
          cmd_cnt_n = cmd_cnt + {16'd0, cmd_acc};
          if (cmd_acc) addr_n = app_addr + STEP;
          en_n = (app_en && !app_rdy) || (cmd_cnt_n < NW);
          if (cmd_cnt_n == NW) state_n = DRAIN;
        end
      end

      DRAIN: begin
        if (!init_calib_complete) begin
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = 1'b0;
        end else if (rd_cnt == NW) begin
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = (err_count == '0);
        end
      end

      DONE: if (start) begin
        state_n = WAIT_CAL;
        done_n  = 1'b0;
        pass_n  = 1'b0;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state        <= IDLE;
      cmd_cnt      <= '0;
      dat_cnt      <= '0;
      rd_cnt       <= '0;
      err_count    <= '0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= '0;
      app_addr     <= BASE_ADDR;
      app_wdf_data <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
`ifdef DDR3_ERR_CAPTURE_EN
      rd_addr      <= BASE_ADDR;
      err_addr     <= '0;
      err_data     <= '0;
`endif
    end else begin
      state        <= state_n;
      cmd_cnt      <= cmd_cnt_n;
      dat_cnt      <= dat_cnt_n;
      rd_cnt       <= rd_cnt_n;
      err_count    <= err_n;
      app_en       <= en_n;
      app_wdf_wren <= wren_n;
      app_cmd      <= cmd_n;
      app_addr     <= addr_n;
      app_wdf_data <= data_n;
      done         <= done_n;
      pass         <= pass_n;
`ifdef DDR3_ERR_CAPTURE_EN
      rd_addr      <= rd_addr_n;
      err_addr     <= err_addr_n;
      err_data     <= err_data_n;
`endif
    end
  end

endmodule

// File: tb/tb_ddr3_test_ctrl.sv
// Self-checking bench for ddr3_test_ctrl: queue-based MIG memory model with optional
// random backpressure/latency and word corruption, driven by a linear directed sequence.
module tb_ddr3_test_ctrl;
  localparam int unsigned NW   = 4;
  localparam int unsigned STEP = 8;
  localparam logic [29:0] BASE = 30'h0;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cal, start;
  logic [29:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         busy, done, pass;
  logic [15:0]  err_count;
`ifdef DDR3_ERR_CAPTURE_EN
  logic [29:0]  err_addr;
  logic [255:0] err_data;
`endif

  ddr3_test_ctrl #(.NUM_WORDS(NW), .ADDR_STEP(STEP), .BASE_ADDR(BASE), .SEED(SEED)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(cal), .start(start),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count)
`ifdef DDR3_ERR_CAPTURE_EN
    , .err_addr(err_addr), .err_data(err_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // memory model state
  logic [255:0] mem [logic [29:0]];
  logic [255:0] wq[$], rq[$], wdata_log[$];
  logic [29:0]  wr_addr_log[$], rd_addr_log[$];
  logic [255:0] rd_word;
  int  lead_viol = 0, lag_viol = 0, hold_viol = 0, end_viol = 0, en_seen = 0;
  bit  bp = 1'b0, corrupt_on = 1'b0, stray = 1'b0;
  logic [29:0] corrupt_addr = '0;
  logic en_stall = 1'b0, wr_stall = 1'b0, p_cal = 1'b0;
  logic [29:0]  p_addr = '0;
  logic [2:0]   p_cmd = '0;
  logic [255:0] p_data = '0;

  function automatic logic [255:0] exp_word(input int unsigned i);
    logic [31:0] w;
    w = SEED ^ i;
    return {8{w}};
  endfunction

  function automatic logic [29:0] exp_addr(input int unsigned i);
    logic [31:0] a;
    a = {2'b00, BASE} + i * STEP;
    return a[29:0];
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ready/valid driving from the memory side
  always @(negedge clk) begin
    app_rdy     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    app_wdf_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rq.size() > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = rq.pop_front();
    end else if (stray) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = {8{32'hDEAD_BEEF}};
    end else begin
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
    end
  end

  // handshake monitor and memory
  always @(posedge clk) begin
    if (rst) begin
      wq.delete(); rq.delete(); mem.delete();
      en_stall = 1'b0; wr_stall = 1'b0;
    end else begin
      if (app_en) en_seen++;
      if (app_wdf_end !== app_wdf_wren) end_viol++;
      if (en_stall && p_cal && (!app_en || app_addr != p_addr || app_cmd != p_cmd)) hold_viol++;
      if (wr_stall && p_cal && (!app_wdf_wren || app_wdf_data != p_data)) hold_viol++;
      if (app_wdf_wren && app_wdf_rdy) begin
        wq.push_back(app_wdf_data);
        wdata_log.push_back(app_wdf_data);
      end
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          wr_addr_log.push_back(app_addr);
          if (wq.size() == 0) lag_viol++;
          else mem[app_addr] = wq.pop_front();
        end else begin
          rd_addr_log.push_back(app_addr);
          rd_word = mem.exists(app_addr) ? mem[app_addr] : '1;
          if (corrupt_on && app_addr == corrupt_addr) rd_word = rd_word ^ 256'h1;
          rq.push_back(rd_word);
        end
      end
      if (wq.size() > 2) lead_viol++;
      en_stall = app_en && !app_rdy;
      wr_stall = app_wdf_wren && !app_wdf_rdy;
    end
    p_cal  = cal;
    p_addr = app_addr;
    p_cmd  = app_cmd;
    p_data = app_wdf_data;
  end

  task automatic clear_logs();
    wr_addr_log.delete(); rd_addr_log.delete(); wdata_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 256'(done), 256'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"},   256'(app_en), 256'(0));
    check({tag, "_wren"}, 256'(app_wdf_wren), 256'(0));
    check({tag, "_end"},  256'(app_wdf_end), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_pass"}, 256'(pass), 256'(0));
    check({tag, "_cmd"},  256'(app_cmd), 256'(0));
    check({tag, "_addr"}, 256'(app_addr), 256'(BASE));
    check({tag, "_data"}, app_wdf_data, '0);
    check({tag, "_err"},  256'(err_count), 256'(0));
    check({tag, "_mask"}, 256'(app_wdf_mask), 256'(0));
`ifdef DDR3_ERR_CAPTURE_EN
    check({tag, "_eaddr"}, 256'(err_addr), 256'(0));
    check({tag, "_edata"}, err_data, '0);
`endif
  endtask

  task automatic check_logs(input string tag);
    check({tag, "_nwr"},  256'(wr_addr_log.size()), 256'(NW));
    check({tag, "_nwd"},  256'(wdata_log.size()), 256'(NW));
    check({tag, "_nrd"},  256'(rd_addr_log.size()), 256'(NW));
    for (int unsigned i = 0; i < NW; i++) begin
      if (i < wr_addr_log.size() && i < wdata_log.size() && i < rd_addr_log.size()) begin
        check({tag, "_wr_addr"}, 256'(wr_addr_log[i]), 256'(exp_addr(i)));
        check({tag, "_wr_data"}, wdata_log[i], exp_word(i));
        check({tag, "_rd_addr"}, 256'(rd_addr_log[i]), 256'(exp_addr(i)));
      end
    end
    check({tag, "_lag"},  256'(lag_viol), 256'(0));
    check({tag, "_lead"}, 256'(lead_viol), 256'(0));
    check({tag, "_hold"}, 256'(hold_viol), 256'(0));
    check({tag, "_wend"}, 256'(end_viol), 256'(0));
    check({tag, "_mask"}, 256'(app_wdf_mask), 256'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; cal = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0; cal = 1'b1;
    @(negedge clk);
    check("idle_busy", 256'(busy), 256'(0));

    // basic run, with a start pulse while busy that must be ignored
    clear_logs();
    pulse_start();
    check("start_busy", 256'(busy), 256'(1));
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done("basic_done");
    check("basic_pass", 256'(pass), 256'(1));
    check("basic_err", 256'(err_count), 256'(0));
    check("basic_busy", 256'(busy), 256'(0));
    repeat (6) @(negedge clk);
    check("basic_hold_done", 256'(done), 256'(1));
    check_logs("basic");

    // stray read data outside READ/DRAIN is ignored
    stray = 1'b1;
    repeat (10) @(negedge clk);
    stray = 1'b0;
    check("stray_err", 256'(err_count), 256'(0));
    check("stray_pass", 256'(pass), 256'(1));

    // random backpressure and read latency
    bp = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      pulse_start();
      wait_done("bp_done");
      check("bp_pass", 256'(pass), 256'(1));
      check("bp_err", 256'(err_count), 256'(0));
      check_logs("bp");
    end
    bp = 1'b0;

    // corrupted word 2
    corrupt_on = 1'b1; corrupt_addr = exp_addr(2);
    clear_logs();
    pulse_start();
    wait_done("bad_done");
    check("bad_err", 256'(err_count), 256'(1));
    check("bad_pass", 256'(pass), 256'(0));
`ifdef DDR3_ERR_CAPTURE_EN
    check("bad_eaddr", 256'(err_addr), 256'(exp_addr(2)));
    check("bad_edata", err_data, exp_word(2) ^ 256'h1);
`endif
    corrupt_on = 1'b0;

    // start from DONE clears done and err_count
    clear_logs();
    pulse_start();
    check("rerun_done_clr", 256'(done), 256'(0));
    check("rerun_busy", 256'(busy), 256'(1));
    wait_done("rerun_done");
    check("rerun_err", 256'(err_count), 256'(0));
    check("rerun_pass", 256'(pass), 256'(1));

    // calibration held low for 100 cycles
    cal = 1'b0;
    clear_logs();
    en_seen = 0;
    pulse_start();
    repeat (100) @(negedge clk);
    check("cal_no_en", 256'(en_seen), 256'(0));
    check("cal_busy", 256'(busy), 256'(1));
    cal = 1'b1;
    wait_done("cal_done");
    check("cal_pass", 256'(pass), 256'(1));
    check_logs("cal");

    // calibration lost during READ
    pulse_start();
    n = 0;
    while (!(app_en && app_cmd == 3'b001) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drop_reach_read", 256'(app_en && app_cmd == 3'b001), 256'(1));
    cal = 1'b0;
    @(negedge clk);
    check("drop_en", 256'(app_en), 256'(0));
    check("drop_wren", 256'(app_wdf_wren), 256'(0));
    check("drop_done", 256'(done), 256'(1));
    check("drop_pass", 256'(pass), 256'(0));
    cal = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of WRITE
    pulse_start();
    n = 0;
    while (!app_wdf_wren && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_write", 256'(app_wdf_wren), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_busy", 256'(busy), 256'(0));
    check("midrst_idle_done", 256'(done), 256'(0));

    // normal run after the abort
    clear_logs();
    pulse_start();
    wait_done("post_done");
    check("post_pass", 256'(pass), 256'(1));
    check_logs("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
